// File: rtl/keypad_if.sv
// Key report handshake between the keypad scanner and its consumer.
interface keypad_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_down;
  logic       overrun;

  modport master (output key_code, output key_valid, output key_down, output overrun,
                  input  key_ack);
  modport slave  (input  key_code, input  key_valid, input  key_down, input  overrun,
                  output key_ack);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row-multiplexed sampling, frame debounce, one report per press.
//   state      | meaning
//   S_IDLE     | no key accepted, waiting for a single-key frame
//   S_DEBOUNCE | candidate key seen, counting identical frames
//   S_HELD     | key accepted and still pressed
//   S_RELEASE  | key absent, counting empty frames before rearming
module keypad_scanner #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  keypad_if.master   kp
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DB_N     = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

  logic [3:0]       col_s1, col_s2;
  logic [DIV_W-1:0] div;
  logic [1:0]       row_idx;
  logic [15:0]      snapshot;
  logic             eval;
  logic             tick;

  state_t           state;
  logic [3:0]       cand;
  logic [3:0]       cnt;
  logic [3:0]       cnt_inc;
  logic [4:0]       hits;
  logic [3:0]       code_c;
  logic             single;
  logic             none;
  logic             accept;

  assign tick    = (div == DIV_LAST);
  assign cnt_inc = cnt + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1   <= 4'hF;
      col_s2   <= 4'hF;
      div      <= '0;
      row_idx  <= 2'd0;
      row_n    <= 4'b1110;
      snapshot <= 16'h0000;
      eval     <= 1'b0;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
      eval   <= tick && (row_idx == 2'd3);
      if (tick) begin
        div                            <= '0;
        snapshot[{row_idx, 2'b00} +: 4] <= ~col_s2;
        row_idx                        <= row_idx + 2'd1;
        row_n                          <= {row_n[2:0], row_n[3]};
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  // Any frame with more than one closed switch is ambiguous and reads as no key.
  always_comb begin
    hits   = 5'd0;
    code_c = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snapshot[i]) begin
        hits   = hits + 5'd1;
        code_c = 4'(i);
      end
    end
    single = eval && (hits == 5'd1);
    none   = eval && (hits != 5'd1);
    accept = single && (((state == S_IDLE) && (DB_N == 4'd1)) ||
                        ((state == S_DEBOUNCE) && (code_c == cand) && (cnt_inc == DB_N)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cand         <= 4'd0;
      cnt          <= 4'd0;
      kp.key_code  <= 4'd0;
      kp.key_valid <= 1'b0;
      kp.key_down  <= 1'b0;
      kp.overrun   <= 1'b0;
    end else begin
      if (eval) begin
        case (state)
          S_IDLE: begin
            if (single) begin
              cand <= code_c;
              cnt  <= 4'd1;
              if (DB_N == 4'd1) begin
                state       <= S_HELD;
                kp.key_down <= 1'b1;
              end else begin
                state <= S_DEBOUNCE;
              end
            end
          end
          S_DEBOUNCE: begin
            if (none) begin
              state <= S_IDLE;
            end else if (code_c != cand) begin
              cand <= code_c;
              cnt  <= 4'd1;
            end else if (cnt_inc == DB_N) begin
              state       <= S_HELD;
              kp.key_down <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          S_HELD: begin
            if (none) begin
              cnt <= 4'd1;
              if (DB_N == 4'd1) begin
                state       <= S_IDLE;
                kp.key_down <= 1'b0;
              end else begin
                state <= S_RELEASE;
              end
            end
          end
          default: begin
            if (single) begin
              state <= S_HELD;
            end else if (cnt_inc == DB_N) begin
              state       <= S_IDLE;
              kp.key_down <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        endcase
      end

      // An ack landing on the acceptance cycle consumes the old report, not the new one.
      if (accept) begin
        kp.key_code  <= code_c;
        kp.key_valid <= 1'b1;
        if (kp.key_ack)
          kp.overrun <= 1'b0;
        else if (kp.key_valid)
          kp.overrun <= 1'b1;
      end else if (kp.key_ack && kp.key_valid) begin
        kp.key_valid <= 1'b0;
        kp.overrun   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, frame-level reference model, directed presses.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DS = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] mask;

  keypad_if kp ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk   (clk),
    .rst   (rst),
    .col_n (col_n),
    .row_n (row_n),
    .kp    (kp)
  );

  int checks   = 0;
  int failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Physical matrix: a closed switch pulls its column low while its row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && mask[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles counted from reset release, frames judged as whole sets of keys.
  int          m_cyc  = 0;
  bit          m_eval = 1'b0;
  logic [15:0] m_frame = 16'h0;
  logic [15:0] m_h1 = 16'h0, m_h2 = 16'h0;
  bit          m_down = 1'b0;
  int          run_code = 0, run_len = 0, rel_len = 0;
  logic [3:0]  e_code = 4'd0;
  bit          e_valid = 1'b0, e_ov = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_cyc = 0; m_eval = 0; m_frame = 16'h0; m_h1 = 16'h0; m_h2 = 16'h0;
        m_down = 0; run_code = 0; run_len = 0; rel_len = 0;
        e_code = 4'd0; e_valid = 0; e_ov = 0;
      end else begin
        int  pc;
        int  cd;
        bit  acc;
        acc = 0;
        pc  = 0;
        cd  = 0;
        if (m_eval) begin
          for (int i = 0; i < 16; i++)
            if (m_frame[i]) begin pc++; cd = i; end
          if (!m_down) begin
            if (pc == 1) begin
              if (run_len > 0 && cd == run_code) run_len++;
              else begin run_code = cd; run_len = 1; end
              if (run_len >= DS) begin acc = 1; m_down = 1; run_len = 0; rel_len = 0; end
            end else run_len = 0;
          end else begin
            if (pc != 1) begin
              rel_len++;
              if (rel_len >= DS) begin m_down = 0; rel_len = 0; end
            end else rel_len = 0;
          end
        end
        if (acc) begin
          if (kp.key_ack) e_ov = 0;
          else if (e_valid) e_ov = 1;
          e_code  = 4'(cd);
          e_valid = 1;
        end else if (kp.key_ack && e_valid) begin
          e_valid = 0;
          e_ov    = 0;
        end
        m_eval = 0;
        if (m_cyc % SD == SD - 1) begin
          int row;
          row = (m_cyc / SD) % 4;
          m_frame[row*4 +: 4] = m_h2[row*4 +: 4];
          if (row == 3) m_eval = 1;
        end
        m_h2 = m_h1;
        m_h1 = mask;
        m_cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("row_n",     row_n, ~(4'b0001 << ((m_cyc / SD) % 4)));
      chk("key_down",  {3'b0, kp.key_down},  {3'b0, m_down});
      chk("key_valid", {3'b0, kp.key_valid}, {3'b0, e_valid});
      chk("overrun",   {3'b0, kp.overrun},   {3'b0, e_ov});
      if (e_valid) chk("key_code", kp.key_code, e_code);
      else if (!rst) chk("key_code_rst", kp.key_code, 4'd0);
    end
  end

  task automatic align_frame();
    int n = 0;
    while (m_cyc % (4*SD) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (m_cyc % (4*SD) != 0) chk("align_timeout", 4'd1, 4'd0);
  endtask

  task automatic hold_frames(input logic [15:0] m, input int n);
    align_frame();
    mask = m;
    repeat (4*SD*n) @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input int exp_cyc, input int t0);
    int n = 0;
    while (!kp.key_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!kp.key_valid) chk({name, "_timeout"}, 4'd0, 4'd1);
    else begin
      checks++;
      if (m_cyc - t0 != exp_cyc) begin
        failures++;
        $display("FAIL %s latency actual=%0d expected=%0d", name, m_cyc - t0, exp_cyc);
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b0;
    mask = 16'h0;
    kp.key_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_row_n", row_n, 4'b1110);
    chk("rst_valid", {3'b0, kp.key_valid}, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_row1", row_n, 4'b1101);
    repeat (28) @(negedge clk);
    chk("idle_valid", {3'b0, kp.key_valid}, 4'd0);
    chk("idle_down",  {3'b0, kp.key_down},  4'd0);

    // key 9 held three frames: report two cycles after the second frame end
    align_frame();
    mask = 16'h0200;
    t0 = m_cyc;
    wait_valid("press9", 33, t0);
    align_frame();
    chk("press9_code", kp.key_code, 4'd9);
    chk("press9_down", {3'b0, kp.key_down}, 4'd1);

    // unacknowledged report followed by key 3 -> overrun
    hold_frames(16'h0000, 2);
    hold_frames(16'h0008, 2);
    repeat (4) @(negedge clk);
    chk("ovr_code",  kp.key_code, 4'd3);
    chk("ovr_valid", {3'b0, kp.key_valid}, 4'd1);
    chk("ovr_flag",  {3'b0, kp.overrun},   4'd1);
    kp.key_ack = 1'b1;
    @(negedge clk);
    kp.key_ack = 1'b0;
    @(negedge clk);
    chk("ack_valid", {3'b0, kp.key_valid}, 4'd0);
    chk("ack_ovr",   {3'b0, kp.overrun},   4'd0);
    hold_frames(16'h0000, 2);

    // bounce: on, off, on, off never reaches two identical frames
    hold_frames(16'h0200, 1);
    hold_frames(16'h0000, 1);
    hold_frames(16'h0200, 1);
    hold_frames(16'h0000, 2);
    repeat (4) @(negedge clk);
    chk("bounce_valid", {3'b0, kp.key_valid}, 4'd0);
    chk("bounce_down",  {3'b0, kp.key_down},  4'd0);

    // two keys in row 1 are ambiguous
    hold_frames(16'h0050, 4);
    hold_frames(16'h0000, 1);
    repeat (4) @(negedge clk);
    chk("multi_valid", {3'b0, kp.key_valid}, 4'd0);
    chk("multi_down",  {3'b0, kp.key_down},  4'd0);

    // reset while debouncing key 6 with key 5 still reported
    hold_frames(16'h0020, 2);
    repeat (4) @(negedge clk);
    chk("k5_code", kp.key_code, 4'd5);
    hold_frames(16'h0000, 2);
    align_frame();
    mask = 16'h0040;
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_row",   row_n, 4'b1110);
    chk("mid_rst_code",  kp.key_code, 4'd0);
    chk("mid_rst_valid", {3'b0, kp.key_valid}, 4'd0);
    chk("mid_rst_down",  {3'b0, kp.key_down},  4'd0);
    chk("mid_rst_ovr",   {3'b0, kp.overrun},   4'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    t0 = m_cyc;
    wait_valid("post_rst", 33, t0);
    chk("post_rst_code", kp.key_code, 4'd6);
    hold_frames(16'h0000, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad.
- Drives one row low at a time, samples the four column lines, debounces over whole scan frames, and reports one encoded key per press through a valid/ack handshake.
- It is the input-side counterpart of the multiplexed seven-segment driver and uses the same time-multiplexed row-select scheme.
- Sits between the board keypad pins and the control logic.

Parameters:
- SCAN_DIV, 25000: clk cycles spent on each row before sampling and advancing; legal range 4 and up.
- DEBOUNCE_SCANS, 4: consecutive identical frames required to accept a press or a release; legal range 1 to 15.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- col_n  input  4  keypad column lines, active-low (pulled up externally), asynchronous to clk
- key_ack  input  1  consumer acknowledge; one-cycle pulse, clears key_valid
- row_n  output  4  row drive, active-low one-hot
- key_code  output  4  code of the last accepted key, row*4+col
- key_valid  output  1  high from acceptance until acknowledged
- key_down  output  1  high while the accepted key is held or its release is being debounced
- overrun  output  1  sticky; a new press was accepted while key_valid was still high

Behaviour:
Reset (rst low, asynchronous):
- row_n=4'b1110, key_code=0, key_valid=0, key_down=0, overrun=0.
- Divider=0, row index=0, snapshot=0, FSM=IDLE, debounce count=0.
- Reset mid-scan or mid-debounce discards all partial state.

Synchronizer:
- col_n passes through 2 flops before any use.

Scan timing:
- Divider counts 0..SCAN_DIV-1 and wraps.
- The cycle where divider==SCAN_DIV-1 is the "tick".
- On a tick: the synchronized ~col_n is stored into snapshot[row], then the row index advances (3 wraps to 0) and row_n rotates (1110 -> 1101 -> 1011 -> 0111 -> 1110).
- Frame = 4 rows = 4*SCAN_DIV cycles.
- Frame end = tick of row 3.

Frame evaluation (cycle after frame-end tick, T+1):
- Exactly one snapshot bit set: result = SINGLE(code = row*4+col).
- Zero bits set: result = NONE.
- Two or more bits set: result = NONE (ghosting/ambiguous; ignored).

FSM, updated once per frame evaluation:
- IDLE: SINGLE -> DEBOUNCE, cand=code, cnt=1; then if DEBOUNCE_SCANS==1, accept immediately -> HELD.
- DEBOUNCE:
  - SINGLE with same code: cnt+1; when cnt reaches DEBOUNCE_SCANS, accept -> HELD.
  - SINGLE with different code: cand=new code, cnt=1.
  - NONE: -> IDLE.
- HELD: NONE -> RELEASE, cnt=1 (-> IDLE directly if DEBOUNCE_SCANS==1); any SINGLE stays HELD.
- RELEASE: NONE: cnt+1; when cnt reaches DEBOUNCE_SCANS -> IDLE. SINGLE (any code) -> HELD with no new report.
- key_down = state is HELD or RELEASE, registered.

Acceptance (registered, visible at T+2 after the qualifying frame-end tick T):
- key_valid==0: key_code<=cand, key_valid<=1.
- key_valid==1 and key_ack low: key_code<=cand, overrun<=1; key_valid stays 1.
- Acceptance and key_ack in the same cycle: key_code<=cand, key_valid stays 1, overrun<=0.

Acknowledge:
- key_ack with key_valid high and no acceptance that cycle: key_valid<=0, overrun<=0.
- key_ack while key_valid is low: ignored.

Holding a key never produces more than one acceptance. A new report requires a full release debounce back to IDLE.

Test Plan:
(Bench values: SCAN_DIV=4, DEBOUNCE_SCANS=2, frame = 16 cycles.)
- Reset, then idle with col_n=4'hF: row_n steps 1110, 1101, 1011, 0111 every 4 cycles, wraps after 16 cycles -> key_valid, key_down and overrun stay 0.
- Press key at row 2, col 1 (col_n bit1 low only while row_n=1011), held for 3 frames -> key_code=9, key_valid=1 two cycles after the 2nd frame-end tick, key_down=1; no second report while held.
- Bounce pattern: press present for 1 frame, absent for 1, present for 1, then released -> no key_valid, FSM returns to IDLE.
- Accept key 9, no ack; release for 2 frames; press row 0, col 3 for 2 frames -> key_code=3, key_valid=1, overrun=1; a single key_ack pulse -> key_valid=0, overrun=0.
- Keys row 1 col 0 and row 1 col 2 held together for 4 frames -> no acceptance (multi-key treated as NONE).
- Assert rst low during DEBOUNCE with a key held -> all outputs return to reset values immediately; after release of rst, a full DEBOUNCE_SCANS frames are needed before key_valid rises.
